// File: rtl/uart_mmio_ctrl.sv
// MMIO bridge between the MEM stage and the UART byte interfaces: RX FIFO, TX holding register, registered read-back.
// Optional free-running cycle counter at 0x80000010 enabled by UART_CYCLE_COUNTER_EN.
module uart_mmio_ctrl #(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned RX_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] ALUOutM,
  input  logic [5:0]  opcodeM,
  input  logic [31:0] wdM,
  output logic [31:0] uartRdW,
  output logic        uartSelW,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  localparam int unsigned CW = RX_AW + 1;

  localparam logic [2:0] OFF_RX_CTRL = 3'd0;
  localparam logic [2:0] OFF_RX_DATA = 3'd1;
  localparam logic [2:0] OFF_TX_CTRL = 3'd2;
  localparam logic [2:0] OFF_TX_DATA = 3'd3;
`ifdef UART_CYCLE_COUNTER_EN
  localparam logic [2:0] OFF_CYCLE   = 3'd4;
`endif

  // State
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RX_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_full_q, tx_full_d;
  logic             tx_drop_q, tx_drop_d;
  logic [31:0]      uart_rd_q, uart_rd_d;
  logic             uart_sel_q, uart_sel_d;
`ifdef UART_CYCLE_COUNTER_EN
  logic [31:0]      cyc_q, cyc_d;
`endif

  // Decode and datapath intermediates
  logic        hit_c, is_load_c, is_store_c, rd_acc_c, wr_acc_c;
  logic [2:0]  off_c;
  logic        rx_empty_c, push_c, pop_c, drain_c, tx_wr_c;
  logic [31:0] rdata_c;
  logic        unused_c;

  assign unused_c = ^{ALUOutM[27:5], ALUOutM[1:0], wdM[31:8]};

  // Access decode
  always_comb begin
    hit_c      = (ALUOutM[31:28] == 4'h8);
    off_c      = ALUOutM[4:2];
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    case (opcodeM)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load_c  = 1'b1;
      6'h28, 6'h29, 6'h2B:               is_store_c = 1'b1;
      default: ;
    endcase
    rd_acc_c = hit_c & is_load_c & ~stall;
    wr_acc_c = hit_c & is_store_c & ~stall;
  end

  // Read data mux, sampled from pre-edge state
  always_comb begin
    rx_empty_c = (count_q == CW'(0));
    rdata_c    = 32'h0;
    case (off_c)
      OFF_RX_CTRL: rdata_c = {31'b0, ~rx_empty_c};
      OFF_RX_DATA: if (!rx_empty_c) rdata_c = {24'b0, rx_mem_q[rd_ptr_q]};
      OFF_TX_CTRL: rdata_c = {30'b0, tx_drop_q, ~tx_full_q};
`ifdef UART_CYCLE_COUNTER_EN
      OFF_CYCLE:   rdata_c = cyc_q;
`endif
      default: ;
    endcase
  end

  // RX FIFO next state
  always_comb begin
    push_c   = DataOutValid & rx_rdy_q;
    pop_c    = rd_acc_c & (off_c == OFF_RX_DATA) & ~rx_empty_c;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_c)  rd_ptr_d = rd_ptr_q + RX_AW'(1);
    if (push_c) wr_ptr_d = wr_ptr_q + RX_AW'(1);
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    rx_rdy_d = (count_d != CW'(RX_DEPTH));
  end

  // TX holding register; a write during a completing handshake refills it
  always_comb begin
    drain_c   = tx_full_q & DataInReady;
    tx_wr_c   = wr_acc_c & (off_c == OFF_TX_DATA);
    tx_data_d = tx_data_q;
    tx_full_d = tx_full_q;
    tx_drop_d = tx_drop_q;
    if (rd_acc_c && (off_c == OFF_TX_CTRL)) tx_drop_d = 1'b0;
    if (tx_wr_c) begin
      if (!tx_full_q || drain_c) begin
        tx_data_d = wdM[7:0];
        tx_full_d = 1'b1;
      end else begin
        tx_drop_d = 1'b1;
      end
    end else if (drain_c) begin
      tx_full_d = 1'b0;
    end
  end

  // Writeback return; held across stalls
  always_comb begin
    uart_sel_d = uart_sel_q;
    uart_rd_d  = uart_rd_q;
    if (!stall) begin
      uart_sel_d = rd_acc_c;
      if (rd_acc_c) uart_rd_d = rdata_c;
    end
  end

`ifdef UART_CYCLE_COUNTER_EN
  // Store clears, otherwise free-running
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (wr_acc_c && (off_c == OFF_CYCLE)) cyc_d = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= 32'h0;
    else     cyc_q <= cyc_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rx_rdy_q   <= 1'b1;
      tx_data_q  <= 8'h0;
      tx_full_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
      uart_rd_q  <= 32'h0;
      uart_sel_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rx_rdy_q   <= rx_rdy_d;
      tx_data_q  <= tx_data_d;
      tx_full_q  <= tx_full_d;
      tx_drop_q  <= tx_drop_d;
      uart_rd_q  <= uart_rd_d;
      uart_sel_q <= uart_sel_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (!rst && push_c) rx_mem_q[wr_ptr_q] <= DataOut;
  end

  assign uartRdW      = uart_rd_q;
  assign uartSelW     = uart_sel_q;
  assign DataIn       = tx_data_q;
  assign DataInValid  = tx_full_q;
  assign DataOutReady = rx_rdy_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: queue-based reference model, directed scenarios then random traffic.
module tb_uart_mmio_ctrl;

  localparam int unsigned RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [5:0]  opcodeM = 6'h0;
  logic [31:0] wdM = 32'h0;
  logic [31:0] uartRdW;
  logic        uartSelW;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady = 1'b0;
  logic [7:0]  DataOut = 8'h0;
  logic        DataOutValid = 1'b0;
  logic        DataOutReady;

  uart_mmio_ctrl #(.RX_DEPTH(RX_DEPTH), .RX_AW(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ALUOutM(ALUOutM), .opcodeM(opcodeM), .wdM(wdM),
    .uartRdW(uartRdW), .uartSelW(uartSelW), .DataIn(DataIn), .DataInValid(DataInValid),
    .DataInReady(DataInReady), .DataOut(DataOut), .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    bit          rd_known;
    logic [31:0] rd;
    bit          txv;
    logic [7:0]  txd;
    bit          rxr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state
  logic [7:0]  m_rx[$];
  bit          m_tx_full, m_drop, m_sel, m_known;
  logic [7:0]  m_tx_byte;
  logic [31:0] m_rd, m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Model the coming edge from the currently driven inputs, queue the expectation, advance
  task automatic step();
    exp_t e;
    bit ld, st, acc, ready_pre, drain;
    logic [2:0]  off;
    logic [31:0] rv;
    ld  = opcodeM inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    st  = opcodeM inside {6'h28, 6'h29, 6'h2B};
    acc = (ALUOutM[31:28] == 4'h8) && (ld || st) && !stall;
    off = ALUOutM[4:2];
    if (rst) begin
      m_rx.delete();
      m_tx_full = 0; m_drop = 0; m_tx_byte = 8'h0;
      m_sel = 0; m_rd = 32'h0; m_known = 1; m_cyc = 32'h0;
    end else begin
      rv = 32'h0;
      if (acc && ld) begin
        case (off)
          3'd0: rv = (m_rx.size() != 0) ? 32'h1 : 32'h0;
          3'd1: rv = (m_rx.size() != 0) ? {24'h0, m_rx[0]} : 32'h0;
          3'd2: rv = {30'h0, m_drop, !m_tx_full};
`ifdef UART_CYCLE_COUNTER_EN
          3'd4: rv = m_cyc;
`endif
          default: rv = 32'h0;
        endcase
      end
      ready_pre = m_rx.size() < RX_DEPTH;
      drain     = m_tx_full && DataInReady;
      if (acc && ld && off == 3'd1 && m_rx.size() != 0) void'(m_rx.pop_front());
      if (DataOutValid && ready_pre) m_rx.push_back(DataOut);
      if (acc && ld && off == 3'd2) m_drop = 0;
      if (acc && st && off == 3'd3) begin
        if (!m_tx_full || drain) begin m_tx_byte = wdM[7:0]; m_tx_full = 1; end
        else m_drop = 1;
      end else if (drain) m_tx_full = 0;
      m_cyc = (acc && st && off == 3'd4) ? 32'h0 : m_cyc + 32'd1;
      if (!stall) begin
        m_sel = acc && ld;
        if (acc && ld) begin m_rd = rv; m_known = 1; end
        else m_known = 0;
      end
    end
    e.sel = m_sel; e.rd_known = m_known; e.rd = m_rd;
    e.txv = m_tx_full; e.txd = m_tx_byte; e.rxr = m_rx.size() < RX_DEPTH;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ALUOutM = 32'h0; opcodeM = 6'h0; step();
    end
  endtask

  task automatic load(input logic [31:0] a);
    ALUOutM = a; opcodeM = 6'h23; step();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    ALUOutM = a; opcodeM = 6'h2B; wdM = d; step();
  endtask

  // Monitor: compares DUT outputs after each edge against the queued expectation
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("uartSelW", 32'(uartSelW), 32'(e.sel));
      if (e.rd_known) chk("uartRdW", uartRdW, e.rd);
      chk("DataInValid", 32'(DataInValid), 32'(e.txv));
      chk("DataIn", 32'(DataIn), 32'(e.txd));
      chk("DataOutReady", 32'(DataOutReady), 32'(e.rxr));
    end
  end

  logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};

  initial begin
    // Reset held two cycles, then RX ctrl on empty FIFO
    rst = 1; step(); step();
    rst = 0;
    load(32'h8000_0000);
    idle(1);

    // Fill RX FIFO, hold off a fifth byte, drain it
    DataOutValid = 1;
    for (int i = 0; i < 6; i++) begin
      DataOut = 8'h41 + 8'(i < 4 ? i : 4);
      step();
    end
    DataOutValid = 0;
    for (int i = 0; i < 5; i++) load(32'h8000_0004);
    load(32'h8000_0000);
    idle(1);

    // TX back-pressure, dropped write, ctrl readback
    DataInReady = 0;
    store(32'h8000_000C, 32'h5A);
    idle(3);
    store(32'h8000_000C, 32'h5B);
    load(32'h8000_0008);
    DataInReady = 1; idle(1);
    DataInReady = 0;
    load(32'h8000_0008);
    idle(1);

    // Refill on the completing handshake
    store(32'h8000_000C, 32'h10);
    idle(1);
    DataInReady = 1;
    store(32'h8000_000C, 32'h11);
    DataInReady = 0; idle(1);
    load(32'h8000_0008);
    DataInReady = 1; idle(2);
    DataInReady = 0;

    // Stalled load has no side effects; push and pop together
    DataOutValid = 1; DataOut = 8'h7E; step();
    DataOutValid = 0;
    stall = 1; load(32'h8000_0004); load(32'h8000_0004);
    stall = 0; load(32'h8000_0004);
    DataOutValid = 1; DataOut = 8'h01; idle(1);
    DataOut = 8'h02; load(32'h8000_0004);
    DataOutValid = 0;
    load(32'h8000_0000);
    load(32'h8000_0004);
    load(32'h8000_0004);

    // Reset abandons TX byte and discards RX bytes
    DataOutValid = 1; DataOut = 8'h99; idle(2);
    DataOutValid = 0;
    store(32'h8000_000C, 32'h33);
    rst = 1; step();
    rst = 0;
    load(32'h8000_0000);
    load(32'h8000_0008);

    // Cycle counter window, clear, immediate read
    idle(100);
    load(32'h8000_0010);
    store(32'h8000_0010, 32'h0);
    load(32'h8000_0010);
    stall = 1; store(32'h8000_0010, 32'h0);
    stall = 0; load(32'h8000_0010);

    // Unmapped offsets and non-hit addresses
    load(32'h8000_0018);
    store(32'h8000_001C, 32'hFF);
    load(32'h8000_000C);
    load(32'h0000_0004);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      opcodeM      = ops[$urandom_range(0, 9)];
      ALUOutM      = ($urandom_range(0, 7) == 0) ? $urandom :
                     (32'h8000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)));
      wdM          = $urandom;
      DataOutValid = ($urandom_range(0, 1) == 1);
      DataOut      = 8'($urandom);
      DataInReady  = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 0; stall = 0; DataOutValid = 0; DataInReady = 0;
    idle(2);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
